// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// Request/response bundle between the multicycle datapath (master) and the
// unified instruction/data memory controller (slave).
//
// Signals:
//   read_mem   master->slave  read request strobe
//   write_mem  master->slave  write request strobe (wins over read_mem)
//   addr       master->slave  32-bit byte address
//   wdata      master->slave  store data (rs2)
//   funct3     master->slave  access size/sign from instruction [14:12]
//   mem_out    slave->master  load data, lane shifted and extended
//   mem_busy   slave->master  request captured, access in progress
//   mem_ready  slave->master  one-cycle completion pulse
//   misaligned slave->master  one-cycle pulse with mem_ready: access rejected
// -----------------------------------------------------------------------------
interface mem_ctrl_if;
    logic        read_mem;
    logic        write_mem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] mem_out;
    logic        mem_busy;
    logic        mem_ready;
    logic        misaligned;

    modport master (
        output read_mem, write_mem, addr, wdata, funct3,
        input  mem_out, mem_busy, mem_ready, misaligned
    );

    modport slave (
        input  read_mem, write_mem, addr, wdata, funct3,
        output mem_out, mem_busy, mem_ready, misaligned
    );
endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Word-organised RAM behind a busy/ready handshake with a fixed access
// latency. Handles RV32I byte/halfword/word loads and stores, little-endian,
// with alignment checking. Misaligned requests still take the full latency
// but leave RAM and mem_out untouched.
//
// Ports:
//   clk   in   system clock, rising-edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of mem_ctrl_if (request strobes, addr, wdata,
//              funct3 in; mem_out, mem_busy, mem_ready, misaligned out)
//
// Parameters:
//   ADDR_WIDTH  word-address bits, depth = 2**ADDR_WIDTH words
//   LATENCY     busy cycles per access, 1..15
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request strobe
// WAIT  | request captured, counting down; access at count zero
// DONE  | one-cycle mem_ready (and misaligned if rejected)
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [2:0]              funct3_q, funct3_d;
    size_t                   size_q, size_d;
    logic                    write_q, write_d;
    logic                    misal_q, misal_d;
    logic [31:0]             mem_out_q, mem_out_d;

    logic [31:0]             ram [2**ADDR_WIDTH];

    // Request decode, evaluated against the live bus while in IDLE
    size_t                   req_size;
    logic                    req_misal;

    // Access datapath, driven from the captured request
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [31:0]             rd_word;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;
    logic [31:0]             load_val;
    logic [3:0]              byte_en;
    logic [31:0]             st_data;
    logic                    ram_we;

    // Store codes other than sb/sh are full-word; load codes use funct3[1:0]
    // with bit 2 only selecting zero extension.
    always_comb begin
        req_size = SZ_W;
        if (bus.write_mem) begin
            if (bus.funct3 == 3'b000)      req_size = SZ_B;
            else if (bus.funct3 == 3'b001) req_size = SZ_H;
        end else begin
            if (bus.funct3[1:0] == 2'b00)      req_size = SZ_B;
            else if (bus.funct3[1:0] == 2'b01) req_size = SZ_H;
        end
        req_misal = ((req_size == SZ_H) && bus.addr[0]) ||
                    ((req_size == SZ_W) && (bus.addr[1:0] != 2'b00));
    end

    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign rd_word  = ram[word_idx];
    assign rd_byte  = rd_word[8*addr_q[1:0] +: 8];
    assign rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        case (funct3_q)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'b0, rd_byte};
            3'b101:  load_val = {16'b0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Replicate store data across lanes; byte enables pick the target lanes
    always_comb begin
        byte_en = 4'b1111;
        st_data = wdata_q;
        case (size_q)
            SZ_B: begin
                byte_en = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
                byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                st_data = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        size_d    = size_q;
        write_d   = write_q;
        misal_d   = misal_q;
        mem_out_d = mem_out_q;
        ram_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.write_mem || bus.read_mem) begin
                    addr_d   = bus.addr[ADDR_WIDTH+1:0];
                    wdata_d  = bus.wdata;
                    funct3_d = bus.funct3;
                    size_d   = req_size;
                    write_d  = bus.write_mem;
                    misal_d  = req_misal;
                    cnt_d    = CNT_INIT;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!misal_q) begin
                        if (write_q) ram_we    = 1'b1;
                        else         mem_out_d = load_val;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            funct3_q  <= 3'b000;
            size_q    <= SZ_W;
            write_q   <= 1'b0;
            misal_q   <= 1'b0;
            mem_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            funct3_q  <= funct3_d;
            size_q    <= size_d;
            write_q   <= write_d;
            misal_q   <= misal_d;
            mem_out_q <= mem_out_d;
        end
    end

    // RAM has no reset; a reset on the commit edge drops the pending write
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) ram[word_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    assign bus.mem_out    = mem_out_q;
    assign bus.mem_busy   = (state_q == WAIT);
    assign bus.mem_ready  = (state_q == DONE);
    assign bus.misaligned = (state_q == DONE) && misal_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic clk;
    logic rst;
    mem_ctrl_if bus ();

    mem_ctrl #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        exp_mis;
        logic        chk_out;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, then watch until mem_ready (bounded)
    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f3,
                          output int nbusy, output int rdy_at,
                          output logic mis, output logic [31:0] out);
        @(negedge clk);
        bus.write_mem = wr;
        bus.read_mem  = rd;
        bus.addr      = a;
        bus.wdata     = d;
        bus.funct3    = f3;
        @(posedge clk);
        #1;
        bus.write_mem = 1'b0;
        bus.read_mem  = 1'b0;
        nbusy  = 0;
        rdy_at = 0;
        mis    = 1'b0;
        out    = '0;
        for (int k = 1; k <= 40 && rdy_at == 0; k++) begin
            @(negedge clk);
            if (bus.mem_busy) nbusy++;
            if (bus.mem_ready) begin
                rdy_at = k;
                mis    = bus.misaligned;
                out    = bus.mem_out;
            end
        end
    endtask

    int          nb, ra, pulses, nbw;
    logic        ms, saw_ready;
    logic [31:0] mo;

    initial begin
        // wr rd addr wdata f3 exp_mis chk_out exp_out
        vecs.push_back('{1'b1, 1'b0, 32'h10,   32'hDEADBEEF, 3'd2, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h10,   32'h0,        3'd2, 1'b0, 1'b1, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 1'b0, 32'h20,   32'h00000000, 3'd2, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h21,   32'h12345680, 3'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h20,   32'h0,        3'd2, 1'b0, 1'b1, 32'h00008000});
        vecs.push_back('{1'b0, 1'b1, 32'h21,   32'h0,        3'd0, 1'b0, 1'b1, 32'hFFFFFF80});
        vecs.push_back('{1'b0, 1'b1, 32'h21,   32'h0,        3'd4, 1'b0, 1'b1, 32'h00000080});
        vecs.push_back('{1'b1, 1'b0, 32'h30,   32'h1111AAAA, 3'd2, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h32,   32'h55558001, 3'd1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h30,   32'h0,        3'd2, 1'b0, 1'b1, 32'h8001AAAA});
        vecs.push_back('{1'b0, 1'b1, 32'h32,   32'h0,        3'd1, 1'b0, 1'b1, 32'hFFFF8001});
        vecs.push_back('{1'b0, 1'b1, 32'h32,   32'h0,        3'd5, 1'b0, 1'b1, 32'h00008001});
        vecs.push_back('{1'b1, 1'b0, 32'h50,   32'h12345678, 3'd2, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h50,   32'h0,        3'd3, 1'b0, 1'b1, 32'h12345678});
        vecs.push_back('{1'b0, 1'b1, 32'h13,   32'h0,        3'd2, 1'b1, 1'b1, 32'h12345678});
        vecs.push_back('{1'b1, 1'b0, 32'h11,   32'h0000FFFF, 3'd1, 1'b1, 1'b1, 32'h12345678});
        vecs.push_back('{1'b0, 1'b1, 32'h10,   32'h0,        3'd2, 1'b0, 1'b1, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 1'b0, 32'h1000, 32'h0BADF00D, 3'd2, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h0,    32'h0,        3'd2, 1'b0, 1'b1, 32'h0BADF00D});
        vecs.push_back('{1'b0, 1'b1, 32'h1050, 32'h0,        3'd2, 1'b0, 1'b1, 32'h12345678});
        vecs.push_back('{1'b0, 1'b1, 32'h33,   32'h0,        3'd1, 1'b1, 1'b1, 32'h12345678});
        vecs.push_back('{1'b1, 1'b0, 32'h23,   32'h000000FE, 3'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h23,   32'h0,        3'd0, 1'b0, 1'b1, 32'hFFFFFFFE});
        vecs.push_back('{1'b0, 1'b1, 32'h22,   32'h0,        3'd5, 1'b0, 1'b1, 32'h0000FE00});
        vecs.push_back('{1'b1, 1'b1, 32'h60,   32'hA5A5A5A5, 3'd2, 1'b0, 1'b1, 32'h0000FE00});
        vecs.push_back('{1'b0, 1'b1, 32'h60,   32'h0,        3'd2, 1'b0, 1'b1, 32'hA5A5A5A5});
        vecs.push_back('{1'b1, 1'b0, 32'h52,   32'h99999999, 3'd4, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h50,   32'h0,        3'd2, 1'b0, 1'b1, 32'h12345678});
        vecs.push_back('{1'b0, 1'b1, 32'h12,   32'h0,        3'd0, 1'b0, 1'b1, 32'hFFFFFFAD});
        vecs.push_back('{1'b0, 1'b1, 32'h13,   32'h0,        3'd4, 1'b0, 1'b1, 32'h000000DE});
        vecs.push_back('{1'b1, 1'b0, 32'h40,   32'h11112222, 3'd2, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h40,   32'h0,        3'd2, 1'b0, 1'b1, 32'h11112222});

        // Reset, with a read request held high to show reset priority
        rst           = 1'b1;
        bus.read_mem  = 1'b1;
        bus.write_mem = 1'b0;
        bus.addr      = 32'h10;
        bus.wdata     = '0;
        bus.funct3    = 3'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy",  {31'b0, bus.mem_busy},   32'h0);
        check("reset ready", {31'b0, bus.mem_ready},  32'h0);
        check("reset mis",   {31'b0, bus.misaligned}, 32'h0);
        check("reset out",   bus.mem_out,             32'h0);
        rst          = 1'b0;
        bus.read_mem = 1'b0;
        @(negedge clk);
        check("post-reset idle", {31'b0, bus.mem_busy}, 32'h0);

        foreach (vecs[i]) begin
            access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
                   nb, ra, ms, mo);
            check($sformatf("v%0d busy cycles", i), nb, LAT);
            check($sformatf("v%0d ready cycle", i), ra, LAT + 1);
            check($sformatf("v%0d misaligned", i), {31'b0, ms}, {31'b0, vecs[i].exp_mis});
            if (vecs[i].chk_out)
                check($sformatf("v%0d mem_out", i), mo, vecs[i].exp_out);
        end

        // read_mem held through WAIT: must yield a single completion
        @(negedge clk);
        bus.read_mem = 1'b1;
        bus.addr     = 32'h30;
        bus.funct3   = 3'd2;
        @(posedge clk);
        #1;
        pulses = 0;
        nbw    = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.mem_busy) nbw++;
            if (bus.mem_ready) begin
                pulses++;
                bus.read_mem = 1'b0;
                check("held read out", bus.mem_out, 32'h8001AAAA);
            end
        end
        bus.read_mem = 1'b0;
        check("held read pulses", pulses, 1);
        check("held read busy", nbw, LAT);

        // Reset during the first and the last WAIT cycle of a store
        for (int d = 1; d <= LAT; d++) begin
            @(negedge clk);
            bus.write_mem = 1'b1;
            bus.addr      = 32'h40;
            bus.wdata     = 32'hCAFEF00D;
            bus.funct3    = 3'd2;
            @(posedge clk);
            #1;
            bus.write_mem = 1'b0;
            repeat (d) @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check($sformatf("rst%0d busy", d),  {31'b0, bus.mem_busy},   32'h0);
            check($sformatf("rst%0d ready", d), {31'b0, bus.mem_ready},  32'h0);
            check($sformatf("rst%0d mis", d),   {31'b0, bus.misaligned}, 32'h0);
            check($sformatf("rst%0d out", d),   bus.mem_out,             32'h0);
            saw_ready = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (bus.mem_ready) saw_ready = 1'b1;
            end
            check($sformatf("rst%0d no ready", d), {31'b0, saw_ready}, 32'h0);
            access(1'b0, 1'b1, 32'h40, 32'h0, 3'd2, nb, ra, ms, mo);
            check($sformatf("rst%0d old data", d), mo, 32'h11112222);
            check($sformatf("rst%0d reread ready", d), ra, LAT + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
